mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the rv32i core load/store
//  port and the host bridge port (program load / debug). Runs an FSM that
//  sequences one memory access at a time, returns read data and a one-cycle
//  ack, and drives core_stall so the core holds its PC while it waits.
// PARAMETERS
//  ADDR_W        32  byte-address width of both requester ports and mem_addr
//  READ_LATENCY  1   cycles from the mem_en cycle to valid mem_rdata; legal 1..4
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous reset, active high
//  core_req     in   1       core access request; held with stable payload until core_ack
//  core_we      in   1       1=write, 0=read
//  core_addr    in   ADDR_W  byte address
//  core_wdata   in   32      write data
//  core_be      in   4       byte enables
//  core_ack     out  1       one-cycle completion pulse
//  core_rdata   out  32      read data; valid while core_ack=1, held until next core read ack
//  core_stall   out  1       core_req & ~core_ack (combinational)
//  host_req/host_we/host_addr/host_wdata/host_be  in   same widths and rules as core_*
//  host_ack     out  1       one-cycle completion pulse
//  host_rdata   out  32      read data, same rules as core_rdata
//  mem_en       out  1       RAM access strobe, exactly one cycle per transaction
//  mem_we       out  1       RAM write enable, qualified by mem_en
//  mem_addr     out  ADDR_W  byte address, passed unmodified from the winner
//  mem_wdata    out  32      write data
//  mem_be       out  4       byte enables
//  mem_rdata    in   32      RAM read data, valid READ_LATENCY cycles after mem_en
// BEHAVIOUR
//  - Reset: state=IDLE; mem_en, mem_we, core_ack, host_ack = 0; mem_addr,
//    mem_wdata, mem_be, core_rdata, host_rdata = 0; last_grant=HOST, so the
//    core wins the first tie; wait counter = 0.
//  - FSM states: IDLE, ISSUE, WAIT, ACK.
//    IDLE:  no req -> IDLE. Any req -> choose the winner, latch its
//           we/addr/wdata/be into the mem_* registers -> ISSUE.
//    ISSUE: mem_en=1 for this one cycle. Write -> ACK. Read -> load counter
//           with READ_LATENCY-1 -> WAIT.
//    WAIT:  counter decrements each cycle. At 0, capture mem_rdata into the
//           winner's rdata register -> ACK.
//    ACK:   winner's ack=1 for this one cycle. Update last_grant -> IDLE.
//  - Latency from the first IDLE cycle with req=1 to the ack cycle: write 2,
//    read 2+READ_LATENCY. No pipelining; one transaction is in flight at a time.
//  - Requesters sample ack at the clock edge and drop or renew req at that
//    edge. A req still high in the following IDLE cycle starts a new transaction.
//  - Arbitration (round-robin): one requester -> it wins. Both request -> the
//    requester that is not last_grant wins. The loser keeps req high, stays
//    stalled, and wins the next IDLE.
//  - A req that rises while the FSM is busy waits for IDLE. mem_* inputs are
//    not re-sampled mid-transaction, so payload changes during a transaction
//    have no effect.
//  - A write with be=4'b0000 is still issued (mem_en=1, no bytes change) and acked.
//  - The non-winner's rdata is never modified. Acks are mutually exclusive.
//  - Reset mid-transaction: return to IDLE next cycle. No ack is issued, the
//    in-flight read data is discarded, and mem_en is low in the cycle after reset.
// CONFIGURATION
//  - MEM_ARBITER_HOST_PRIORITY_EN defined: strict priority. host_req always wins
//    in IDLE and last_grant is ignored. The core can be starved while the host
//    streams, as required during program load.
//  - Not defined: round-robin as above. Both modes have identical latencies.
// TESTING
//  1. Core read, addr 0x8000_0010, RL=1, mem_rdata=0xDEAD_BEEF -> mem_en pulses
//     once with addr 0x8000_0010 and we=0; core_ack 3 cycles after req;
//     core_rdata=0xDEAD_BEEF; core_stall high for 3 cycles.
//  2. Host write, addr 0x8000_0000, wdata 0x1234_5678, be=4'hF -> mem_en=mem_we=1
//     in ISSUE; host_ack 2 cycles after req; core_ack stays 0.
//  3. Both req every cycle after reset, round-robin -> grants alternate core,
//     host, core, host. Under MEM_ARBITER_HOST_PRIORITY_EN -> host, host, host, ...
//     and core_stall stays 1.
//  4. RL=4 read -> core_ack exactly 6 cycles after req; rdata captured 4 cycles
//     after mem_en.
//  5. reset asserted in WAIT of a read -> no ack; next cycle state=IDLE with
//     mem_en=0 and rdata=0; a fresh core read then completes normally.
//  6. Core req held high across its ack -> a second transaction starts in the
//     next IDLE, with 1 cycle of gap between ack and the next mem_en.

Source files
------------

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM between the core load/store port
//   and the host bridge port. One access is in flight at a time. The FSM goes
//   IDLE -> ISSUE -> (WAIT) -> ACK. It returns read data with a one-cycle ack
//   and stalls the core while the core's request is pending.
//
//   Parameters:
//     ADDR_W        byte-address width of requester ports and mem_addr
//     READ_LATENCY  cycles from the mem_en cycle to valid mem_rdata (1..4)
//
//   Ports:
//     clk, reset                      rising-edge clock, sync active-high reset
//     core_req/we/addr/wdata/be       core request, payload held until core_ack
//     core_ack, core_rdata            one-cycle completion pulse, held read data
//     core_stall                      core_req & ~core_ack
//     host_req/we/addr/wdata/be       host request, same rules as core
//     host_ack, host_rdata            host completion pulse and read data
//     mem_en/we/addr/wdata/be         RAM strobe and registered payload
//     mem_rdata                       RAM read data
//
//   Build option:
//     MEM_ARBITER_HOST_PRIORITY_EN    when defined, host_req always wins (strict
//                                     priority). Otherwise arbitration is
//                                     round-robin.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  output logic              core_ack,
  output logic [31:0]       core_rdata,
  output logic              core_stall,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [3:0]        host_be,
  output logic              host_ack,
  output logic [31:0]       host_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  state_t     state;
  logic       sel_host;   // winner of the transaction in flight
  logic [1:0] wait_cnt;
  logic       pick_host;  // arbitration result for the current IDLE cycle

`ifdef MEM_ARBITER_HOST_PRIORITY_EN
  assign pick_host = host_req;
`else
  logic last_host;        // last completed grant went to the host

  // The host wins alone, or on a tie when the core was served last.
  assign pick_host = host_req & (~core_req | ~last_host);
`endif

  assign core_stall = core_req & ~core_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_host   <= 1'b0;
      wait_cnt   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      core_ack   <= 1'b0;
      host_ack   <= 1'b0;
      core_rdata <= '0;
      host_rdata <= '0;
`ifndef MEM_ARBITER_HOST_PRIORITY_EN
      last_host  <= 1'b1;
`endif
    end else begin
      // Strobes are single-cycle; they are raised only on the transition
      // into the state that owns them.
      mem_en   <= 1'b0;
      core_ack <= 1'b0;
      host_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (core_req || host_req) begin
            sel_host  <= pick_host;
            mem_we    <= pick_host ? host_we    : core_we;
            mem_addr  <= pick_host ? host_addr  : core_addr;
            mem_wdata <= pick_host ? host_wdata : core_wdata;
            mem_be    <= pick_host ? host_be    : core_be;
            mem_en    <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          if (mem_we) begin
            core_ack <= ~sel_host;
            host_ack <= sel_host;
            state    <= ACK;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            if (sel_host) begin
              host_rdata <= mem_rdata;
            end else begin
              core_rdata <= mem_rdata;
            end
            core_ack <= ~sel_host;
            host_ack <= sel_host;
            state    <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        ACK: begin
`ifndef MEM_ARBITER_HOST_PRIORITY_EN
          last_host <= sel_host;
`endif
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int unsigned RL = 1;

  typedef struct {
    bit          host;
    bit          rd;
    logic [31:0] rdata;
    int unsigned cyc;
  } ack_t;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, host_req, host_we;
  logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
  logic [3:0]  core_be, host_be;
  logic        core_ack, core_stall, host_ack;
  logic [31:0] core_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // second instance with READ_LATENCY=4
  logic        c4_req, c4_we;
  logic [31:0] c4_addr;
  logic        c4_ack, c4_stall, h4_ack;
  logic [31:0] c4_rdata, h4_rdata;
  logic        mem4_en, mem4_we;
  logic [31:0] mem4_addr, mem4_wdata, mem4_rdata;
  logic [3:0]  mem4_be;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  ack_t ack_q[$];
  mem_t mem_q[$];
  ack_t ack4_q[$];
  ack_t ea, ea4;
  mem_t em;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32), .READ_LATENCY(RL)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_be(core_be), .core_ack(core_ack),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_be(host_be), .host_ack(host_ack),
    .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .READ_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .core_req(c4_req), .core_we(c4_we), .core_addr(c4_addr),
    .core_wdata(32'h0), .core_be(4'hF), .core_ack(c4_ack),
    .core_rdata(c4_rdata), .core_stall(c4_stall),
    .host_req(1'b0), .host_we(1'b0), .host_addr(32'h0),
    .host_wdata(32'h0), .host_be(4'h0), .host_ack(h4_ack),
    .host_rdata(h4_rdata),
    .mem_en(mem4_en), .mem_we(mem4_we), .mem_addr(mem4_addr),
    .mem_wdata(mem4_wdata), .mem_be(mem4_be), .mem_rdata(mem4_rdata)
  );

  // RAM model, latency 1; junk is driven whenever no read data is due
  logic        ram_init;
  logic [31:0] ram [16];
  logic [31:0] rd_d;
  logic        rd_v;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      ram[4] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) ram[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    rd_v <= mem_en & ~mem_we;
    rd_d <= ram[mem_addr[5:2]];
  end
  assign mem_rdata = rd_v ? rd_d : 32'h0BAD_0BAD;

  // RAM model, latency 4; read data is 0xCAFE0000 ^ address
  logic [31:0] d4 [4];
  logic        v4 [4];

  always @(posedge clk) begin
    d4[0] <= 32'hCAFE_0000 ^ mem4_addr;
    v4[0] <= mem4_en & ~mem4_we;
    for (int i = 1; i < 4; i++) begin
      d4[i] <= d4[i-1];
      v4[i] <= v4[i-1];
    end
  end
  assign mem4_rdata = v4[3] ? d4[3] : 32'h0BAD_0BAD;

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    bad++;
    $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // Monitor for the latency-1 instance
  always @(negedge clk) begin
    if (core_ack && host_ack) begin
      total++;
      fail("ack_exclusive", 32'h3, 32'h1);
    end else if (core_ack || host_ack) begin
      if (ack_q.size() == 0) begin
        total++;
        fail("ack_unexpected", {31'b0, host_ack}, 32'hFFFF_FFFF);
      end else begin
        ea = ack_q.pop_front();
        chk("ack_who", {31'b0, host_ack}, {31'b0, ea.host});
        chk("ack_cycle", cyc, ea.cyc);
        if (ea.rd) chk("ack_rdata", ea.host ? host_rdata : core_rdata, ea.rdata);
      end
    end
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        total++;
        fail("mem_en_unexpected", mem_addr, 32'hFFFF_FFFF);
      end else begin
        em = mem_q.pop_front();
        chk("mem_cycle", cyc, em.cyc);
        chk("mem_we", {31'b0, mem_we}, {31'b0, em.we});
        chk("mem_addr", mem_addr, em.addr);
        chk("mem_wdata", mem_wdata, em.wdata);
        chk("mem_be", {28'b0, mem_be}, {28'b0, em.be});
      end
    end
  end

  // Monitor for the latency-4 instance
  always @(negedge clk) begin
    if (h4_ack) begin
      total++;
      fail("rl4_host_ack", 32'h1, 32'h0);
    end
    if (c4_ack) begin
      if (ack4_q.size() == 0) begin
        total++;
        fail("rl4_ack_unexpected", c4_rdata, 32'hFFFF_FFFF);
      end else begin
        ea4 = ack4_q.pop_front();
        chk("rl4_ack_cycle", cyc, ea4.cyc);
        if (ea4.rd) chk("rl4_rdata", c4_rdata, ea4.rdata);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected mem_en/ack for a transaction whose first IDLE cycle is c
  task automatic push_exp(input bit host, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] rd, input int unsigned c, input bit acked);
    ack_t a;
    mem_t m;
    m.cyc = c + 1; m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
    mem_q.push_back(m);
    a.host = host; a.rd = !we; a.rdata = rd;
    a.cyc = we ? c + 2 : c + 2 + RL;
    if (acked) ack_q.push_back(a);
  endtask

  task automatic run(input bit host, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] rd,
                     output int unsigned n_stall, output logic stall_ack);
    bit got;
    push_exp(host, we, addr, wdata, be, rd, cyc, 1'b1);
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata; host_be = be;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_be = be;
    end
    n_stall = 0; stall_ack = 1'b0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (host ? host_ack : core_ack) begin
        got = 1'b1;
        stall_ack = core_stall;
      end else if (core_stall) begin
        n_stall++;
      end
    end
    if (!got) begin
      total++;
      fail("txn_timeout", 32'h0, 32'h1);
    end
    @(posedge clk); #1;
    if (host) host_req = 1'b0; else core_req = 1'b0;
  endtask

  task automatic run4(input logic we, input logic [31:0] addr, input logic [31:0] rd);
    ack_t a;
    bit got;
    int unsigned n_en, en_cyc, c;
    c = cyc;
    a.host = 1'b0; a.rd = !we; a.rdata = rd; a.cyc = we ? c + 2 : c + 6;
    ack4_q.push_back(a);
    c4_req = 1'b1; c4_we = we; c4_addr = addr;
    got = 1'b0; n_en = 0; en_cyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem4_en) begin n_en++; en_cyc = cyc; end
      if (c4_ack) got = 1'b1;
    end
    if (!got) begin
      total++;
      fail("rl4_timeout", 32'h0, 32'h1);
    end
    chk("rl4_mem_en_count", n_en, 1);
    chk("rl4_mem_en_cycle", en_cyc, c + 1);
    @(posedge clk); #1;
    c4_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned ns, c, n;
    logic sa;

    reset = 1'b1; ram_init = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = '0;
    c4_req = 1'b0; c4_we = 1'b0; c4_addr = '0;
    tick(3);
    ram_init = 1'b0;

    // reset state
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_acks", {30'b0, core_ack, host_ack}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_host_rdata", host_rdata, 32'h0);
    chk("rst_stall", {31'b0, core_stall}, 32'h0);
    reset = 1'b0;
    tick(1);

    // core read, latency 1
    run(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, ns, sa);
    chk("t1_stall_cycles", ns, 3);
    chk("t1_stall_at_ack", {31'b0, sa}, 32'h0);
    chk("t1_rdata_held", core_rdata, 32'hDEAD_BEEF);

    // host write then read back; core data untouched
    run(1'b1, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0, ns, sa);
    run(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h1234_5678, ns, sa);
    chk("core_rdata_kept", core_rdata, 32'hDEAD_BEEF);

    // be=0 write is issued and acked but changes nothing
    run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0, ns, sa);
    run(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'h1234_5678, ns, sa);

    // partial byte-enable write
    run(1'b0, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, 32'h0, ns, sa);
    run(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 32'h00BB_00DD, ns, sa);
    chk("host_rdata_kept", host_rdata, 32'h1234_5678);

    // both requesting continuously from reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst2_core_rdata", core_rdata, 32'h0);
    chk("rst2_host_rdata", host_rdata, 32'h0);
    c = cyc;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h8000_0020; core_wdata = 32'h1111_1111; core_be = 4'hF;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h8000_0024; host_wdata = 32'h2222_2222; host_be = 4'hF;
`ifdef MEM_ARBITER_HOST_PRIORITY_EN
    for (int i = 0; i < 4; i++)
      push_exp(1'b1, 1'b1, 32'h8000_0024, 32'h2222_2222, 4'hF, 32'h0, c + 3*i, 1'b1);
`else
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        push_exp(1'b0, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 32'h0, c + 3*i, 1'b1);
      else
        push_exp(1'b1, 1'b1, 32'h8000_0024, 32'h2222_2222, 4'hF, 32'h0, c + 3*i, 1'b1);
    end
`endif
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (core_stall) n++;
      @(posedge clk); #1;
    end
    core_req = 1'b0; host_req = 1'b0;
`ifdef MEM_ARBITER_HOST_PRIORITY_EN
    chk("t3_stall_cycles", n, 12);
`else
    chk("t3_stall_cycles", n, 10);
`endif

    // core req held across its ack: back-to-back reads with one idle cycle
    c = cyc;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8000_0010; core_wdata = 32'h0; core_be = 4'hF;
    push_exp(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, c, 1'b1);
    push_exp(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, c + 4, 1'b1);
    tick(8);
    core_req = 1'b0;

    // reset while waiting for read data
    c = cyc;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8000_0010; core_wdata = 32'h0; core_be = 4'hF;
    push_exp(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 32'h0, c, 1'b0);
    tick(2);
    reset = 1'b1; core_req = 1'b0;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_mem_en", {31'b0, mem_en}, 32'h0);
    chk("t5_core_ack", {31'b0, core_ack}, 32'h0);
    chk("t5_core_rdata", core_rdata, 32'h0);
    @(posedge clk); #1;
    run(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 32'h00BB_00DD, ns, sa);

    // latency-4 instance: read ack after 6 cycles, write after 2
    run4(1'b0, 32'h8000_0010, 32'h4AFE_0010);
    run4(1'b1, 32'h8000_0014, 32'h0);
    run4(1'b0, 32'h8000_0100, 32'h4AFE_0100);

    tick(4);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("ack4_q_drained", ack4_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
